// File: rtl/password_attempt_ctrl.sv
// Attempt sequencer and lockout controller for the 4-digit checker.
// Grants one attempt at a time, tracks failures and timed windows.
module password_attempt_ctrl #(
  parameter int TICK_DIV     = 50_000_000,
  parameter int MAX_FAILS    = 3,
  parameter int LOCK_TICKS   = 30,
  parameter int UNLOCK_TICKS = 10,
  parameter int ARM_TICKS    = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       res_valid,
  input  logic       res_ok,
  output logic       chk_en,
  output logic       unlocked,
  output logic       locked,
  output logic [2:0] fail_cnt,
  output logic [7:0] remain,
  output logic       tick
);

  localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PMAX = PW'(TICK_DIV - 1);
  localparam logic [7:0] T_ARM = 8'(ARM_TICKS);
  localparam logic [7:0] T_UNL = 8'(UNLOCK_TICKS);
  localparam logic [7:0] T_LCK = 8'(LOCK_TICKS);
  localparam logic [3:0] FMAX4 = 4'(MAX_FAILS);
  localparam logic [2:0] FMAX3 = 3'(MAX_FAILS);

  typedef enum logic [1:0] {
    READY   = 2'd0,
    ARMED   = 2'd1,
    UNLOCK  = 2'd2,
    LOCKOUT = 2'd3
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic [PW-1:0]   r_presc;
  logic [7:0]      r_timer;
  logic [7:0]      w_timer_nx;
  logic [2:0]      r_fail;
  logic [2:0]      w_fail_nx;
  logic [3:0]      w_fail_inc;
  logic            r_tick;
  logic            r_chk_en;
  logic            r_unlocked;
  logic            r_locked;
  logic            w_tick;
  logic            w_expire;
  logic            w_trans;

  // Internal tick event; the exported pulse is its registered copy.
  assign w_tick     = (r_presc == PMAX);
  assign w_expire   = w_tick && (r_timer == 8'd1);
  assign w_fail_inc = {1'b0, r_fail} + 4'd1;
  assign w_trans    = (w_next != r_state);

  // Next state, timer and failure count from current state and inputs.
  always_comb begin
    w_next     = r_state;
    w_timer_nx = r_timer;
    w_fail_nx  = r_fail;
    unique case (r_state)
      READY: begin
        w_timer_nx = 8'd0;
        if (start) begin
          w_next     = ARMED;
          w_timer_nx = T_ARM;
        end
      end
      ARMED: begin
        if (res_valid) begin
          if (res_ok) begin
            w_next     = UNLOCK;
            w_timer_nx = T_UNL;
            w_fail_nx  = 3'd0;
          end else if (w_fail_inc >= FMAX4) begin
            w_next     = LOCKOUT;
            w_timer_nx = T_LCK;
            w_fail_nx  = FMAX3;
          end else begin
            w_next     = READY;
            w_timer_nx = 8'd0;
            w_fail_nx  = w_fail_inc[2:0];
          end
        end else if (w_expire) begin
          w_next     = READY;
          w_timer_nx = 8'd0;
        end else if (w_tick) begin
          w_timer_nx = r_timer - 8'd1;
        end
      end
      UNLOCK: begin
        if (w_expire) begin
          w_next     = READY;
          w_timer_nx = 8'd0;
        end else if (w_tick) begin
          w_timer_nx = r_timer - 8'd1;
        end
      end
      LOCKOUT: begin
        if (w_expire) begin
          w_next     = READY;
          w_timer_nx = 8'd0;
          w_fail_nx  = 3'd0;
        end else if (w_tick) begin
          w_timer_nx = r_timer - 8'd1;
        end
      end
      default: begin
        w_next     = READY;
        w_timer_nx = 8'd0;
      end
    endcase
  end

  // State, timer, failure count and registered status flags.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state    <= READY;
      r_timer    <= 8'd0;
      r_fail     <= 3'd0;
      r_chk_en   <= 1'b0;
      r_unlocked <= 1'b0;
      r_locked   <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_timer    <= w_timer_nx;
      r_fail     <= w_fail_nx;
      r_chk_en   <= (w_next == ARMED);
      r_unlocked <= (w_next == UNLOCK);
      r_locked   <= (w_next == LOCKOUT);
    end
  end

  // Prescaler restarts on every state change so windows are whole ticks.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_presc <= '0;
      r_tick  <= 1'b0;
    end else begin
      r_tick <= w_tick;
      if (w_trans || w_tick) begin
        r_presc <= '0;
      end else begin
        r_presc <= r_presc + 1'b1;
      end
    end
  end

  assign chk_en   = r_chk_en;
  assign unlocked = r_unlocked;
  assign locked   = r_locked;
  assign fail_cnt = r_fail;
  assign remain   = r_timer;
  assign tick     = r_tick;

endmodule

// File: tb/tb_password_attempt_ctrl.sv
// Randomized bench for password_attempt_ctrl.
// Reference model tracks cycles spent in each state.
module tb_password_attempt_ctrl;

  localparam int TD   = 4;
  localparam int MAXF = 3;
  localparam int LT   = 5;
  localparam int UT   = 2;
  localparam int AT   = 3;

  localparam int M_READY = 0;
  localparam int M_ARMED = 1;
  localparam int M_UNL   = 2;
  localparam int M_LOCK  = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       res_valid;
  logic       res_ok;
  logic       chk_en;
  logic       unlocked;
  logic       locked;
  logic [2:0] fail_cnt;
  logic [7:0] remain;
  logic       tick;

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;

  int m_st   = M_READY;
  int m_e    = 0;
  int m_fail = 0;
  int m_tick = 0;
  int n_lock = 0;
  bit lock_rst_done = 0;

  password_attempt_ctrl #(
    .TICK_DIV    (TD),
    .MAX_FAILS   (MAXF),
    .LOCK_TICKS  (LT),
    .UNLOCK_TICKS(UT),
    .ARM_TICKS   (AT)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .res_valid(res_valid),
    .res_ok   (res_ok),
    .chk_en   (chk_en),
    .unlocked (unlocked),
    .locked   (locked),
    .fail_cnt (fail_cnt),
    .remain   (remain),
    .tick     (tick)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%0d exp=%0d", tag, cyc, got, exp);
    end
  endtask

  function automatic int dur(input int s);
    case (s)
      M_ARMED: return AT;
      M_UNL:   return UT;
      M_LOCK:  return LT;
      default: return 0;
    endcase
  endfunction

  task automatic model_step(input bit r, input bit s,
                            input bit v, input bit ok);
    int ns;
    int n;
    bit tk;
    bit ex;
    if (!r) begin
      m_st   = M_READY;
      m_e    = 0;
      m_fail = 0;
      m_tick = 0;
      return;
    end
    n  = dur(m_st);
    tk = ((m_e % TD) == TD - 1);
    ex = (m_st != M_READY) && (m_e == n * TD - 1);
    ns = m_st;
    case (m_st)
      M_READY: if (s) ns = M_ARMED;
      M_ARMED: begin
        if (v) begin
          if (ok) begin
            ns = M_UNL;
            m_fail = 0;
          end else if (m_fail + 1 >= MAXF) begin
            ns = M_LOCK;
            m_fail = MAXF;
          end else begin
            ns = M_READY;
            m_fail = m_fail + 1;
          end
        end else if (ex) begin
          ns = M_READY;
        end
      end
      M_UNL: if (ex) ns = M_READY;
      default: if (ex) begin
        ns = M_READY;
        m_fail = 0;
      end
    endcase
    if (ns == M_LOCK && m_st != M_LOCK) n_lock++;
    m_tick = int'(tk);
    m_e    = (ns != m_st) ? 0 : m_e + 1;
    m_st   = ns;
  endtask

  task automatic check_all();
    int rem;
    rem = (m_st == M_READY) ? 0 : dur(m_st) - m_e / TD;
    chk("chk_en",   int'(chk_en),   int'(m_st == M_ARMED));
    chk("unlocked", int'(unlocked), int'(m_st == M_UNL));
    chk("locked",   int'(locked),   int'(m_st == M_LOCK));
    chk("fail_cnt", int'(fail_cnt), m_fail);
    chk("remain",   int'(remain),   rem);
    chk("tick",     int'(tick),     m_tick);
  endtask

  initial begin
    bit r;
    int vdiv;
    rst = 1'b0;
    start = 1'b0;
    res_valid = 1'b0;
    res_ok = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      cyc = i;
      r = 1'b1;
      if (i < 2) r = 1'b0;
      else if ($urandom_range(0, 299) == 0) r = 1'b0;
      else if (!lock_rst_done && m_st == M_LOCK && m_e == 9) begin
        r = 1'b0;
        lock_rst_done = 1;
      end
      vdiv = ((i / 500) % 2 == 1) ? 40 : 5;
      rst       = r;
      start     = ($urandom_range(0, 3) == 0);
      res_valid = ($urandom_range(0, vdiv - 1) == 0);
      res_ok    = ($urandom_range(0, 3) == 0);
      if (i == 1) begin
        start     = 1'b1;
        res_valid = 1'b1;
      end
      @(posedge clk);
      model_step(rst, start, res_valid, res_ok);
      #1;
      check_all();
    end
    chk("lockout_seen", int'(n_lock > 0), 1);
    chk("lock_reset_seen", int'(lock_rst_done), 1);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
